// File: rtl/spike_wave_sequencer.sv
// Spike wave sequencer: runs one STDP time wave from 0 to PERIOD and turns
// latched per-channel spike times into level spikes and first-rise pulses.
module spike_wave_sequencer #(
  parameter int LOG_TIME_PERIOD = 3,
  parameter int N_INPUTS        = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_l,
  input  logic                                  start,
  input  logic [N_INPUTS*LOG_TIME_PERIOD-1:0]   in_times,
  input  logic [N_INPUTS-1:0]                   in_silent,
  input  logic                                  step_en,
  input  logic                                  abort,
  output logic                                  ready,
  output logic                                  busy,
  output logic [LOG_TIME_PERIOD:0]              time_val,
  output logic [N_INPUTS-1:0]                   spike_out,
  output logic [N_INPUTS-1:0]                   spike_edge,
  output logic                                  wave_done
);

  localparam int L = LOG_TIME_PERIOD;
  localparam logic [L:0] PERIOD    = {1'b1, {L{1'b0}}};
  localparam logic [L:0] LAST_STEP = PERIOD - {{L{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAMMA
  } state_t;

  state_t                    state_q, state_d;
  logic [L:0]                time_q, time_d;
  logic [N_INPUTS*L-1:0]     times_q, times_d;
  logic [N_INPUTS-1:0]       silent_q, silent_d;
  logic [N_INPUTS-1:0]       prev_q, prev_d;

  // Level spike rule: a live, non-silent channel fires once the wave time reaches its spike time
  always_comb begin
    spike_out = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      spike_out[i] = (state_q != IDLE) && !silent_q[i] &&
                     ({1'b0, times_q[i*L +: L]} <= time_q);
    end
  end

  assign spike_edge = spike_out & ~prev_q;
  assign ready      = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign time_val   = time_q;
  // An abort during the gamma cycle cancels the completion pulse
  assign wave_done  = (state_q == GAMMA) && !abort;

  // Next-state logic: wave accept, time stepping, gamma cycle and abort handling
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    times_d  = times_q;
    silent_d = silent_q;
    prev_d   = spike_out;
    case (state_q)
      IDLE: begin
        time_d = '0;
        if (start && !abort) begin
          times_d  = in_times;
          silent_d = in_silent;
          prev_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          time_d  = '0;
          prev_d  = '0;
        end else if (step_en) begin
          time_d = time_q + {{L{1'b0}}, 1'b1};
          if (time_q == LAST_STEP) begin
            state_d = GAMMA;
          end
        end
      end
      GAMMA: begin
        state_d = IDLE;
        time_d  = '0;
        prev_d  = '0;
      end
      default: begin
        state_d = IDLE;
        time_d  = '0;
        prev_d  = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      time_q   <= '0;
      times_q  <= '0;
      silent_q <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      times_q  <= times_d;
      silent_q <= silent_d;
      prev_q   <= prev_d;
    end
  end

endmodule

// File: tb/tb_spike_wave_sequencer.sv
// Directed bench for spike_wave_sequencer (L=3, N=4, PERIOD=8): a vector
// table for whole waves plus hand-written stall, abort and reset sequences.
module tb_spike_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start;
  logic [11:0] in_times;
  logic [3:0]  in_silent;
  logic        step_en;
  logic        abort;
  logic        ready;
  logic        busy;
  logic [3:0]  time_val;
  logic [3:0]  spike_out;
  logic [3:0]  spike_edge;
  logic        wave_done;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0]  F  = 4'hF;
  // ch3=5, ch2=7, ch1=3, ch0=0
  localparam logic [11:0] W  = 12'hBD8;
  // every channel at time 2
  localparam logic [11:0] S2 = 12'h492;
  localparam logic [11:0] T0 = 12'h000;
  localparam logic [11:0] T7 = 12'hFFF;
  localparam logic [14:0] IDLE_EXP = 15'b1_0_0000_0000_0000_0;

  typedef struct {
    logic        start;
    logic [11:0] times;
    logic [3:0]  silent;
    logic        step;
    logic        abort;
    logic        ready;
    logic        busy;
    logic [3:0]  tval;
    logic [3:0]  so;
    logic [3:0]  se;
    logic        wd;
  } vec_t;

  vec_t tbl[$];

  spike_wave_sequencer #(
    .LOG_TIME_PERIOD(3),
    .N_INPUTS(4)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .in_times  (in_times),
    .in_silent (in_silent),
    .step_en   (step_en),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .time_val  (time_val),
    .spike_out (spike_out),
    .spike_edge(spike_edge),
    .wave_done (wave_done)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [11:0] t, input logic [3:0] sil,
                              input logic st, input logic ab, input logic r, input logic b,
                              input logic [3:0] tv, input logic [3:0] so, input logic [3:0] se,
                              input logic wd);
    vec_t v;
    v.start = s;  v.times = t;  v.silent = sil; v.step = st; v.abort = ab;
    v.ready = r;  v.busy = b;   v.tval = tv;    v.so = so;   v.se = se;  v.wd = wd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    start     = v.start;
    in_times  = v.times;
    in_silent = v.silent;
    step_en   = v.step;
    abort     = v.abort;
  endtask

  task automatic checkOutput(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = {ready, busy, time_val, spike_out, spike_edge, wave_done};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got rdy=%b busy=%b t=%0d so=%b se=%b wd=%b, want rdy=%b busy=%b t=%0d so=%b se=%b wd=%b",
               name, act[14], act[13], act[12:9], act[8:5], act[4:1], act[0],
               exp[14], exp[13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  // Drive a vector mid-cycle and check the outputs of that same cycle
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(name, {v.ready, v.busy, v.tval, v.so, v.se, v.wd});
  endtask

  // Wave on times W after the accept cycle: RUN t0..t7, GAMMA, back to idle
  task automatic basic_wave(input string tag);
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 0, 4'b0001, 4'b0001, 0), {tag, "_t0"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 1, 4'b0001, 4'b0000, 0), {tag, "_t1"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 2, 4'b0001, 4'b0000, 0), {tag, "_t2"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 3, 4'b0011, 4'b0010, 0), {tag, "_t3"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 4, 4'b0011, 4'b0000, 0), {tag, "_t4"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 5, 4'b1011, 4'b1000, 0), {tag, "_t5"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 6, 4'b1011, 4'b0000, 0), {tag, "_t6"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 7, 4'b1111, 4'b0100, 0), {tag, "_t7"});
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 8, 4'b1111, 4'b0000, 1), {tag, "_gamma"});
    run_vec(mk(0, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), {tag, "_idle"});
  endtask

  initial begin
    start = 0; in_times = '0; in_silent = '0; step_en = 0; abort = 0;
    rst_l = 1'b1;
    #2 rst_l = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_state", IDLE_EXP);
    rst_l = 1'b1;

    // Basic wave: edges at t0 (ch0), t3 (ch1), t5 (ch3), t7 (ch2)
    tbl.push_back(mk(1, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 0, 4'b0001, 4'b0001, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 1, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 2, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 3, 4'b0011, 4'b0010, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 4, 4'b0011, 4'b0000, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 5, 4'b1011, 4'b1000, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 6, 4'b1011, 4'b0000, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 7, 4'b1111, 4'b0100, 0));
    tbl.push_back(mk(0, W, 0, 1, 0, 0, 1, 8, 4'b1111, 4'b0000, 1));
    tbl.push_back(mk(0, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));
    // Silent ch2, all times 2
    tbl.push_back(mk(1, S2, 4'b0100, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, S2, 4'b0100, 1, 0, 0, 1, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, S2, 4'b0100, 1, 0, 0, 1, 1, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, S2, 4'b0100, 1, 0, 0, 1, 2, 4'b1011, 4'b1011, 0));
    for (int t = 3; t < 8; t++)
      tbl.push_back(mk(0, S2, 4'b0100, 1, 0, 0, 1, 4'(t), 4'b1011, 4'b0000, 0));
    tbl.push_back(mk(0, S2, 4'b0100, 1, 0, 0, 1, 8, 4'b1011, 4'b0000, 1));
    tbl.push_back(mk(0, S2, 4'b0100, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));
    // Back-to-back with start held high; in_times changes during RUN are ignored
    tbl.push_back(mk(1, T0, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, T7, 0, 1, 0, 0, 1, 0, F, F, 0));
    for (int t = 1; t < 8; t++)
      tbl.push_back(mk(1, T7, 0, 1, 0, 0, 1, 4'(t), F, 4'b0000, 0));
    tbl.push_back(mk(1, T7, 0, 1, 0, 0, 1, 8, F, 4'b0000, 1));
    tbl.push_back(mk(1, T7, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));
    for (int t = 0; t < 7; t++)
      tbl.push_back(mk(1, T0, 0, 1, 0, 0, 1, 4'(t), 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, T0, 0, 1, 0, 0, 1, 7, F, F, 0));
    tbl.push_back(mk(0, T0, 0, 1, 0, 0, 1, 8, F, 4'b0000, 1));
    tbl.push_back(mk(0, T0, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));

    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // Stall three cycles at t4: time holds, no repeated edges, done 3 cycles later
    run_vec(mk(1, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "stall_accept");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 0, 4'b0001, 4'b0001, 0), "stall_t0");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 1, 4'b0001, 4'b0000, 0), "stall_t1");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 2, 4'b0001, 4'b0000, 0), "stall_t2");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 3, 4'b0011, 4'b0010, 0), "stall_t3");
    for (int k = 0; k < 3; k++)
      run_vec(mk(0, W, 0, 0, 0, 0, 1, 4, 4'b0011, 4'b0000, 0), $sformatf("stall_hold%0d", k));
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 4, 4'b0011, 4'b0000, 0), "stall_t4");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 5, 4'b1011, 4'b1000, 0), "stall_t5");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 6, 4'b1011, 4'b0000, 0), "stall_t6");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 7, 4'b1111, 4'b0100, 0), "stall_t7");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 8, 4'b1111, 4'b0000, 1), "stall_gamma");
    run_vec(mk(0, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "stall_idle");

    // Abort at t6, idle one cycle, then a full new wave
    run_vec(mk(1, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "abort_accept");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 0, 4'b0001, 4'b0001, 0), "abort_t0");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 1, 4'b0001, 4'b0000, 0), "abort_t1");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 2, 4'b0001, 4'b0000, 0), "abort_t2");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 3, 4'b0011, 4'b0010, 0), "abort_t3");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 4, 4'b0011, 4'b0000, 0), "abort_t4");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 5, 4'b1011, 4'b1000, 0), "abort_t5");
    run_vec(mk(0, W, 0, 1, 1, 0, 1, 6, 4'b1011, 4'b0000, 0), "abort_t6");
    run_vec(mk(0, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "abort_idle");
    run_vec(mk(1, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "abort_restart");
    basic_wave("after_abort");

    // Abort in IDLE wins over a same-cycle start
    run_vec(mk(1, W, 0, 1, 1, 1, 0, 0, 4'b0000, 4'b0000, 0), "idle_abort_start");
    run_vec(mk(0, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "idle_abort_stays");

    // Abort during GAMMA suppresses wave_done
    run_vec(mk(1, T0, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "gabort_accept");
    run_vec(mk(0, T0, 0, 1, 0, 0, 1, 0, F, F, 0), "gabort_t0");
    for (int t = 1; t < 8; t++)
      run_vec(mk(0, T0, 0, 1, 0, 0, 1, 4'(t), F, 4'b0000, 0), $sformatf("gabort_t%0d", t));
    run_vec(mk(0, T0, 0, 1, 1, 0, 1, 8, F, 4'b0000, 0), "gabort_gamma");
    run_vec(mk(0, T0, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "gabort_idle");

    // Asynchronous reset at t5 clears everything immediately
    run_vec(mk(1, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "rst_accept");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 0, 4'b0001, 4'b0001, 0), "rst_t0");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 1, 4'b0001, 4'b0000, 0), "rst_t1");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 2, 4'b0001, 4'b0000, 0), "rst_t2");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 3, 4'b0011, 4'b0010, 0), "rst_t3");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 4, 4'b0011, 4'b0000, 0), "rst_t4");
    run_vec(mk(0, W, 0, 1, 0, 0, 1, 5, 4'b1011, 4'b1000, 0), "rst_t5");
    #1 rst_l = 1'b0;
    #1 checkOutput("rst_async_clear", IDLE_EXP);
    @(negedge clk);
    rst_l = 1'b1;
    #1 checkOutput("rst_release_idle", IDLE_EXP);
    run_vec(mk(0, W, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0), "rst_still_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
